// File: rtl/arm_exec_if.sv
`default_nettype none
// ============================================================================
// Module      : arm_exec_if
// Description : Core <-> execute-datapath bundle. Carries the decoded
//               data-processing operation (valid/ready handshake), the
//               result/flags return path and the memory-stage load write
//               port into the register file.
//               master : issuing core side
//               slave  : arm_exec_datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface arm_exec_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(DATA_W);

  // operation issue
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_alu;
  logic [1:0]        op_shift;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     rn;
  logic [AW-1:0]     rm;
  logic [AW-1:0]     rs;
  logic              sel_shift;
  logic [SW-1:0]     shift_imm;
  logic              sel_A;
  logic              sel_B;
  logic [DATA_W-1:0] imm;
  logic              set_flags;
  // load write port
  logic              ext_w_en;
  logic [AW-1:0]     ext_w_addr;
  logic [DATA_W-1:0] ext_w_data;
  // result return
  logic              res_valid;
  logic [DATA_W-1:0] result;
  logic [3:0]        flags;

  modport master (
    output op_valid, op_alu, op_shift, rd, rn, rm, rs, sel_shift, shift_imm,
           sel_A, sel_B, imm, set_flags, ext_w_en, ext_w_addr, ext_w_data,
    input  op_ready, res_valid, result, flags
  );

  modport slave (
    input  op_valid, op_alu, op_shift, rd, rn, rm, rs, sel_shift, shift_imm,
           sel_A, sel_B, imm, set_flags, ext_w_en, ext_w_addr, ext_w_data,
    output op_ready, res_valid, result, flags
  );
endinterface
`default_nettype wire

// File: rtl/arm_exec_datapath.sv
`default_nettype none
// ============================================================================
// Module      : arm_exec_datapath
// Description : Self-sequenced ARM32 execute datapath: register file (one
//               read-side capture into A/B/S, write-back port + load port),
//               barrel shifter on B, ALU and NZCV register, driven by a
//               four-state IDLE->READ->EXEC->WB sequencer.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - arm_exec_if.slave (op handshake, load port, result)
// Revision    : 1.0 - initial release
// ============================================================================
module arm_exec_datapath #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  arm_exec_if.slave   bus
);
  localparam int AW  = $clog2(NREGS);
  localparam int SW  = $clog2(DATA_W);
  // S holds the full 8-bit register amount, or a wider immediate if DATA_W>256
  localparam int S_W = (SW > 8) ? SW : 8;
  localparam logic [S_W:0] DW_S = (S_W+1)'(DATA_W);
  localparam logic [SW:0]  DW_R = (SW+1)'(DATA_W);

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_ORR = 3'b011, ALU_EOR = 3'b100, ALU_MOV = 3'b101,
                         ALU_MVN = 3'b110, ALU_CMP = 3'b111;
  localparam logic [1:0] SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic [2:0]        alu;
    logic [1:0]        shift;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rn;
    logic [AW-1:0]     rm;
    logic [AW-1:0]     rs;
    logic              sel_shift;
    logic [SW-1:0]     shift_imm;
    logic              sel_a;
    logic              sel_b;
    logic [DATA_W-1:0] imm;
    logic              set_flags;
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [3:0]        nzcv_q, nzcv_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // shifter / ALU intermediates
  logic [DATA_W-1:0] sh_val, rot, a_op, alu_res;
  logic              sh_c, alu_c, alu_v;
  logic [S_W:0]      n_asr;
  logic [SW-1:0]     ror_m;
  logic [DATA_W:0]   sum_add, sum_sub;
  logic [3:0]        nzcv_new;

  // --------------------------------------------------------------------------
  // Barrel shifter. Shifting a one-bit-extended operand yields the value and
  // the last bit shifted out in one expression; over-range amounts fall out
  // as zero naturally, ASR clamps to DATA_W to replicate the sign.
  // --------------------------------------------------------------------------
  always_comb begin
    sh_val = b_q;
    sh_c   = nzcv_q[1];
    n_asr  = ({1'b0, s_q} >= DW_S) ? DW_S : {1'b0, s_q};
    ror_m  = s_q[SW-1:0];
    rot    = (b_q >> ror_m) | (b_q << (DW_R - {1'b0, ror_m}));
    if (op_q.sel_b) begin
      sh_val = op_q.imm;
    end else if (s_q != '0) begin
      case (op_q.shift)
        SH_LSL:  {sh_c, sh_val} = {1'b0, b_q} << s_q;
        SH_LSR:  {sh_val, sh_c} = {b_q, 1'b0} >> s_q;
        SH_ASR:  {sh_val, sh_c} = $signed({b_q, 1'b0}) >>> n_asr;
        default: begin
          // multiples of DATA_W leave rot==b_q; carry is always the new MSB
          sh_val = rot;
          sh_c   = rot[DATA_W-1];
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // ALU and new-flag generation
  // --------------------------------------------------------------------------
  always_comb begin
    a_op    = op_q.sel_a ? '0 : a_q;
    sum_add = {1'b0, a_op} + {1'b0, sh_val};
    sum_sub = {1'b0, a_op} + {1'b0, ~sh_val} + 1'b1;
    alu_res = sh_val;
    alu_c   = sh_c;
    alu_v   = nzcv_q[0];
    case (op_q.alu)
      ALU_ADD: begin
        alu_res = sum_add[DATA_W-1:0];
        alu_c   = sum_add[DATA_W];
        alu_v   = (a_op[DATA_W-1] == sh_val[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != a_op[DATA_W-1]);
      end
      ALU_SUB, ALU_CMP: begin
        alu_res = sum_sub[DATA_W-1:0];
        alu_c   = sum_sub[DATA_W];
        alu_v   = (a_op[DATA_W-1] != sh_val[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != a_op[DATA_W-1]);
      end
      ALU_AND: alu_res = a_op & sh_val;
      ALU_ORR: alu_res = a_op | sh_val;
      ALU_EOR: alu_res = a_op ^ sh_val;
      ALU_MVN: alu_res = ~sh_val;
      default: alu_res = sh_val;
    endcase
    nzcv_new = {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
  end

  // --------------------------------------------------------------------------
  // Sequencer and next-state of all datapath registers
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    nzcv_d  = nzcv_q;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          op_d    = '{alu: bus.op_alu, shift: bus.op_shift, rd: bus.rd,
                      rn: bus.rn, rm: bus.rm, rs: bus.rs,
                      sel_shift: bus.sel_shift, shift_imm: bus.shift_imm,
                      sel_a: bus.sel_A, sel_b: bus.sel_B, imm: bus.imm,
                      set_flags: bus.set_flags};
          state_d = S_READ;
        end
      end
      S_READ: begin
        // reads see regs_q, so a same-cycle load write is not forwarded
        a_d     = regs_q[op_q.rn];
        b_d     = regs_q[op_q.rm];
        s_d     = op_q.sel_shift ? S_W'(regs_q[op_q.rs][7:0]) : S_W'(op_q.shift_imm);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_res;
        if (op_q.set_flags || (op_q.alu == ALU_CMP)) nzcv_d = nzcv_new;
        state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
    // load port first so write-back overrides it on an address collision
    if (bus.ext_w_en) regs_d[bus.ext_w_addr] = bus.ext_w_data;
    if ((state_q == S_WB) && (op_q.alu != ALU_CMP)) regs_d[op_q.rd] = c_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      nzcv_q  <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      nzcv_q  <= nzcv_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.op_ready  = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_WB);
  assign bus.result    = c_q;
  assign bus.flags     = nzcv_q;
endmodule
`default_nettype wire

// File: tb/tb_arm_exec_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_exec_datapath
// Description : Directed scoreboard bench for arm_exec_datapath. Each issued
//               operation pushes its hand-computed result/flags; a monitor
//               pops and compares on every res_valid strobe. Register
//               contents are observed through MOV read-back operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_exec_datapath;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, ORR = 3'd3,
                         EOR = 3'd4, MOV = 3'd5, MVN = 3'd6, CMP = 3'd7;
  localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          hs;
    string       name;
  } exp_t;
  exp_t sb[$];

  arm_exec_if #(.DATA_W(32), .NREGS(16)) bus ();

  arm_exec_datapath #(.DATA_W(32), .NREGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // monitor: compare every result strobe against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_res_valid: got strobe expected none (result 0x%08h)", bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, bus.result, e.res);
        chk({e.name, "_flags"}, {28'd0, bus.flags}, {28'd0, e.fl});
        // handshake edge counts as edge 0; strobe must follow edge 2
        chk({e.name, "_edges_to_strobe"}, cyc - e.hs, 2);
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.ext_w_en = 1'b1; bus.ext_w_addr = a; bus.ext_w_data = d;
    @(posedge clk); #1;
    bus.ext_w_en = 1'b0;
  endtask

  // ext_mode: 0 none, 1 load write during READ, 2 load write during WB
  task automatic do_op(input string nm, input logic [2:0] alu, input logic [1:0] sh,
                       input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                       input logic [3:0] rs, input logic sel_sh, input logic [4:0] shimm,
                       input logic sel_a, input logic sel_b, input logic [31:0] imm,
                       input logic setf, input logic [31:0] exp_res, input logic [3:0] exp_fl,
                       input int ext_mode = 0, input logic [3:0] ext_a = 0,
                       input logic [31:0] ext_d = 0);
    exp_t e;
    int   w;
    w = 0;
    while (!bus.op_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!bus.op_ready) begin
      n_total++;
      $display("FAIL %s_op_ready_timeout: got 0 expected 1", nm);
      return;
    end
    bus.op_alu = alu; bus.op_shift = sh; bus.rd = rd; bus.rn = rn; bus.rm = rm;
    bus.rs = rs; bus.sel_shift = sel_sh; bus.shift_imm = shimm; bus.sel_A = sel_a;
    bus.sel_B = sel_b; bus.imm = imm; bus.set_flags = setf; bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    // scramble fields: latched copy must be used from here on
    bus.op_alu = ~alu; bus.rn = ~rn; bus.rm = ~rm; bus.imm = ~imm;
    e.res = exp_res; e.fl = exp_fl; e.hs = cyc; e.name = nm;
    sb.push_back(e);
    if (ext_mode == 1) begin
      bus.ext_w_en = 1'b1; bus.ext_w_addr = ext_a; bus.ext_w_data = ext_d;
      @(posedge clk); #1;
      bus.ext_w_en = 1'b0;
    end else if (ext_mode == 2) begin
      @(posedge clk); @(posedge clk); #1;
      bus.ext_w_en = 1'b1; bus.ext_w_addr = ext_a; bus.ext_w_data = ext_d;
      @(posedge clk); #1;
      bus.ext_w_en = 1'b0;
    end
  endtask

  task automatic rd_back(input string nm, input logic [3:0] r, input logic [31:0] exp,
                         input logic [3:0] fl);
    do_op(nm, MOV, LSL, r, 4'd0, r, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, exp, fl);
  endtask

  initial begin
    int w;
    bus.op_valid = 0; bus.op_alu = 0; bus.op_shift = 0; bus.rd = 0; bus.rn = 0;
    bus.rm = 0; bus.rs = 0; bus.sel_shift = 0; bus.shift_imm = 0; bus.sel_A = 0;
    bus.sel_B = 0; bus.imm = 0; bus.set_flags = 0; bus.ext_w_en = 0;
    bus.ext_w_addr = 0; bus.ext_w_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_op_ready", {31'd0, bus.op_ready}, 1);
    chk("reset_res_valid", {31'd0, bus.res_valid}, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_flags", {28'd0, bus.flags}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    rd_back("reset_r0", 4'd0, 32'd0, 4'b0000);
    wr(4'd1, 32'd5); wr(4'd2, 32'd3);
    do_op("add_lsl2", ADD, LSL, 4'd0, 4'd1, 4'd2, 4'd0, 1'b0, 5'd2, 1'b0, 1'b0, 0, 1'b1,
          32'd17, 4'b0000);
    rd_back("rb_r0", 4'd0, 32'd17, 4'b0000);

    wr(4'd1, 32'd3); wr(4'd6, 32'h1234);
    do_op("cmp_eq", CMP, LSL, 4'd6, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0,
          32'd0, 4'b0110);
    rd_back("rb_r6_cmp_nowrite", 4'd6, 32'h1234, 4'b0110);

    wr(4'd2, 32'h8000_0000); wr(4'd3, 32'd40);
    do_op("mov_asr40", MOV, ASR, 4'd7, 4'd0, 4'd2, 4'd3, 1'b1, 5'd0, 1'b0, 1'b0, 0, 1'b1,
          32'hFFFF_FFFF, 4'b1010);
    do_op("mov_imm0_keepc", MOV, LSL, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 5'd3, 1'b0, 1'b1, 0, 1'b1,
          32'd0, 4'b0110);
    wr(4'd1, 32'h7FFF_FFFF);
    do_op("add_imm_ovf", ADD, LSL, 4'd8, 4'd1, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'd1, 1'b1,
          32'h8000_0000, 4'b1001);

    wr(4'd1, 32'd10); wr(4'd2, 32'd20);
    do_op("add_wb_vs_ext", ADD, LSL, 4'd4, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0,
          32'd30, 4'b1001, 2, 4'd4, 32'hDEAD);
    rd_back("rb_r4_wb_wins", 4'd4, 32'd30, 4'b1001);
    do_op("add_ext_in_read", ADD, LSL, 4'd9, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0,
          32'd30, 4'b1001, 1, 4'd1, 32'd100);
    rd_back("rb_r1_ext", 4'd1, 32'd100, 4'b1001);

    wr(4'd3, 32'd32); wr(4'd2, 32'h8000_0001);
    do_op("lsr32", MOV, LSR, 4'd10, 4'd0, 4'd2, 4'd3, 1'b1, 5'd0, 1'b0, 1'b0, 0, 1'b1,
          32'd0, 4'b0111);
    wr(4'd3, 32'd33);
    do_op("lsl33", MOV, LSL, 4'd10, 4'd0, 4'd2, 4'd3, 1'b1, 5'd0, 1'b0, 1'b0, 0, 1'b1,
          32'd0, 4'b0101);
    wr(4'd3, 32'd32);
    do_op("ror32", MOV, ROR, 4'd10, 4'd0, 4'd2, 4'd3, 1'b1, 5'd0, 1'b0, 1'b0, 0, 1'b1,
          32'h8000_0001, 4'b1011);
    do_op("ror1", MOV, ROR, 4'd10, 4'd0, 4'd2, 4'd0, 1'b0, 5'd1, 1'b0, 1'b0, 0, 1'b1,
          32'hC000_0000, 4'b1011);

    wr(4'd1, 32'd3); wr(4'd2, 32'd5);
    do_op("sub_borrow", SUB, LSL, 4'd11, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1,
          32'hFFFF_FFFE, 4'b1000);
    wr(4'd1, 32'hF0F0); wr(4'd2, 32'hFF00);
    do_op("and", AND_, LSL, 4'd11, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1,
          32'hF000, 4'b0000);
    do_op("eor", EOR, LSL, 4'd11, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0,
          32'h0FF0, 4'b0000);
    do_op("mvn", MVN, LSL, 4'd11, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1,
          32'hFFFF_00FF, 4'b1000);
    do_op("orr", ORR, LSL, 4'd11, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0,
          32'hFFF0, 4'b1000);
    do_op("add_selA", ADD, LSL, 4'd11, 4'd1, 4'd2, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 1'b0,
          32'hFF00, 4'b1000);

    // reset while an ADD to r5 is in EXEC: no strobe, no write-back
    w = 0;
    while (!bus.op_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus.op_alu = ADD; bus.op_shift = LSL; bus.rd = 4'd5; bus.rn = 4'd1; bus.rm = 4'd2;
    bus.sel_shift = 0; bus.shift_imm = 0; bus.sel_A = 0; bus.sel_B = 0;
    bus.set_flags = 1; bus.op_valid = 1;
    @(posedge clk); #1;
    bus.op_valid = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_op_ready", {31'd0, bus.op_ready}, 1);
    chk("rst_exec_res_valid", {31'd0, bus.res_valid}, 0);
    chk("rst_exec_flags", {28'd0, bus.flags}, 0);
    chk("rst_exec_result", bus.result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_back("rb_r5_after_rst", 4'd5, 32'd0, 4'b0000);
    rd_back("rb_r1_after_rst", 4'd1, 32'd0, 4'b0000);

    w = 0;
    while (sb.size() != 0 && w < 100) begin @(posedge clk); w++; end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/arm_exec_datapath.md
# arm_exec_datapath

Parametrised, self-sequenced execute datapath for the ARM32 core: register file, operand registers A/B/S, barrel shifter, ALU and NZCV status register under an internal four-state sequencer. The core issues one decoded data-processing operation at a time over a valid/ready handshake and receives the result, write-back and updated flags without driving per-register enables itself. A second register-file write port accepts load data from the memory stage.

## Interface
- DATA_W, 32, datapath and register width (power of two, ≥8)
- NREGS, 16, register-file entries; AW = clog2(NREGS)
- SW, clog2(DATA_W), immediate shift-amount width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  operation offered
- op_ready  out  1  sequencer idle, accepts operation
- op_alu  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV, 110 MVN, 111 CMP
- op_shift  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (applied to B operand)
- rd, rn, rm, rs  in  AW each  destination, A source, B source, shift-amount source
- sel_shift  in  1  1: amount = rs[7:0]; 0: amount = shift_imm
- shift_imm  in  SW  immediate shift amount
- sel_A  in  1  1: A operand forced to 0
- sel_B  in  1  1: B operand = imm (shifter bypassed, shifter carry = current C)
- imm  in  DATA_W  immediate operand
- set_flags  in  1  update NZCV (CMP always updates)
- ext_w_en, ext_w_addr, ext_w_data  in  1 / AW / DATA_W  load write port
- res_valid  out  1  one-cycle result strobe
- result  out  DATA_W  C register
- flags  out  4  {N,Z,C,V} status register

## Operation
- All op_* fields, rd..rs, sel_*, shift_imm, imm, set_flags latched on handshake (op_valid & op_ready); inputs ignored afterwards.
- States: IDLE → READ → EXEC → WB → IDLE; no other transitions except reset. op_ready = (state==IDLE), combinational from state.
- READ: A ← reg[rn], B ← reg[rm], S ← amount (rs low 8 bits, zero-extended; or shift_imm).
- EXEC: C ← ALU(A', shift(B,S)); NZCV ← new flags if set_flags or CMP.
- WB: res_valid=1; reg[rd] ← C at end of cycle unless CMP.
- Shifter, amount n: n=0 → pass-through, carry = current C. LSL/LSR: n≥DATA_W → 0, carry = last bit shifted out (n>DATA_W → carry 0). ASR: n≥DATA_W → all sign bits, carry = sign. ROR: rotate by n mod DATA_W; n nonzero multiple of DATA_W → value unchanged, carry = MSB.
- ADD: C = carry-out. SUB/CMP: A − B as A + ~B + 1, C = NOT borrow. V from signed overflow for ADD/SUB/CMP only; logic ops/MOV/MVN take C from shifter, leave V.
- N = result MSB, Z = result==0, both from the full DATA_W result.
- Register file: two write ports. Same address written by WB and ext in one cycle → WB value wins. ext write in the READ cycle to a read address → A/B capture the old value.

## Timing
- Handshake at edge 0; A/B/S valid after edge 1; C/flags after edge 2; res_valid high in cycle after edge 2, register written at edge 3.
- Latency 3 cycles to res_valid; throughput one op per 4 cycles; op_ready returns high in the cycle after WB.
- result holds C until next EXEC; flags hold until next flag-setting EXEC.
- Reset (any state): state IDLE, A/B/S/C/status = 0, all registers = 0; outputs op_ready=1, res_valid=0, result=0, flags=0. In-flight operation dropped, no write-back.

## Test plan
- r1=5, r2=3: ADD rd=r0, LSL #2, set_flags → res_valid 3 cycles after handshake, result=17, r0=17, flags=0000.
- r1=3, r2=3: CMP set_flags=0 → flags Z=1,C=1 (0110), r-file unchanged, res_valid still pulses.
- r2=0x80000000, ASR by rs with r3=40 → B'=0xFFFFFFFF, MOV result 0xFFFFFFFF, flags N=1,C=1 (1010) with set_flags.
- r1=0x7FFFFFFF, ADD imm=1, sel_B=1, set_flags → result 0x80000000, flags N=1,V=1 (1001).
- WB to r4 and ext_w_en r4=0xDEAD in same cycle → r4=result; ext write r1 during READ → A captures old r1.
- Assert rst during EXEC → next cycle op_ready=1, res_valid=0, rd unwritten, flags=0000.
